// File: rtl/spi_shift_engine_pkg.sv
// Shared constants and state encoding for the SPI shift engine.
// Optional feature macro used by this slice: SPI_LSB_FIRST_EN.
package spi_shift_engine_pkg;

    // Default transfer width; the tick constants below are derived from it.
    localparam int unsigned SPI_DATA_WD = 8;
    // Number of SCK edges in one transfer.
    localparam int unsigned EDGE_CNT    = 2 * SPI_DATA_WD;
    // Final tick returns SCK to idle and closes the transfer.
    localparam int unsigned LAST_TICK   = EDGE_CNT + 1;
    localparam int unsigned TICK_CNT_WD = $clog2(LAST_TICK + 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Bus between the SPI register block (master) and the shift engine (slave),
// including the serial pins. lsb_first exists only with SPI_LSB_FIRST_EN.
interface spi_shift_engine_if #(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned DIV_WD  = 8
);
    logic               start;
    logic               cpol;
    logic               cpha;
    logic [DIV_WD-1:0]  clk_div;
    logic [DATA_WD-1:0] data_in;
    logic               miso;
    logic               sck;
    logic               mosi;
    logic               busy;
    logic               done;
    logic [DATA_WD-1:0] data_out;
`ifdef SPI_LSB_FIRST_EN
    logic               lsb_first;

    modport master (
        output start, cpol, cpha, clk_div, data_in, miso, lsb_first,
        input  sck, mosi, busy, done, data_out
    );

    modport slave (
        input  start, cpol, cpha, clk_div, data_in, miso, lsb_first,
        output sck, mosi, busy, done, data_out
    );
`else
    modport master (
        output start, cpol, cpha, clk_div, data_in, miso,
        input  sck, mosi, busy, done, data_out
    );

    modport slave (
        input  start, cpol, cpha, clk_div, data_in, miso,
        output sck, mosi, busy, done, data_out
    );
`endif

endinterface

// File: rtl/spi_clk_tick.sv
// SCK half-period divider: while enabled, counts 0..div and emits a
// single-cycle tick on the terminal count, then reloads to 0.
module spi_clk_tick #(
    parameter int unsigned DIV_WD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_WD-1:0] div,
    output logic              tick
);

    logic [DIV_WD-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == div);

    // Next count: hold at zero when disabled so the first tick is a full period away.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Single-byte SPI master shift engine, all four CPOL/CPHA modes.
// Define SPI_LSB_FIRST_EN to add the lsb_first bus signal (latched at start).
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int unsigned DATA_WD = SPI_DATA_WD,
    parameter int unsigned DIV_WD  = 8
) (
    input logic               mclk,
    input logic               puc_rst,
    spi_shift_engine_if.slave bus
);

    localparam logic [TICK_CNT_WD-1:0] TickOne   = TICK_CNT_WD'(1);
    localparam logic [TICK_CNT_WD-1:0] TickEdgeM = TICK_CNT_WD'(EDGE_CNT - 1);
    localparam logic [TICK_CNT_WD-1:0] TickEdge  = TICK_CNT_WD'(EDGE_CNT);
    localparam logic [TICK_CNT_WD-1:0] TickLast  = TICK_CNT_WD'(LAST_TICK);

    state_e                 state_q, state_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [DIV_WD-1:0]      div_q, div_d;
    logic [DATA_WD-1:0]     tx_q, tx_d;
    logic [DATA_WD-1:0]     rx_q, rx_d;
    logic [DATA_WD-1:0]     data_out_q, data_out_d;
    logic                   mosi_q, mosi_d;
    logic                   sck_q, sck_d;
    logic                   done_q, done_d;
    logic [TICK_CNT_WD-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_CNT_WD-1:0] tick_num;
    logic                   run;
    logic                   tick;
    logic                   first_bit;
    logic                   next_bit;
    logic [DATA_WD-1:0]     tx_shift;
    logic [DATA_WD-1:0]     rx_shift;
    logic                   sample_now;
    logic                   shift_now;
`ifdef SPI_LSB_FIRST_EN
    logic                   lsb_q, lsb_d;
`endif

    assign run      = (state_q == StRun);
    assign tick_num = tick_cnt_q + 1'b1;

    spi_clk_tick #(
        .DIV_WD (DIV_WD)
    ) u_clk_tick (
        .clk  (mclk),
        .rst  (puc_rst),
        .en   (run),
        .div  (div_q),
        .tick (tick)
    );

    // Bit-order helpers: first bit driven, shifted TX register, RX register with miso inserted.
    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        first_bit = bus.lsb_first ? bus.data_in[0] : bus.data_in[DATA_WD-1];
        tx_shift  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        next_bit  = lsb_q ? tx_shift[0] : tx_shift[DATA_WD-1];
        rx_shift  = lsb_q ? {bus.miso, rx_q[DATA_WD-1:1]} : {rx_q[DATA_WD-2:0], bus.miso};
`else
        first_bit = bus.data_in[DATA_WD-1];
        tx_shift  = tx_q << 1;
        next_bit  = tx_shift[DATA_WD-1];
        rx_shift  = {rx_q[DATA_WD-2:0], bus.miso};
`endif
    end

    // Edge decode: cpha=0 samples on odd ticks and shifts on even ticks 2..14;
    // cpha=1 drives on odd ticks 3..15 (tick 1 keeps the MSB) and samples on even ticks.
    always_comb begin
        sample_now = 1'b0;
        shift_now  = 1'b0;
        if (cpha_q) begin
            sample_now = !tick_num[0] && (tick_num <= TickEdge);
            shift_now  = tick_num[0] && (tick_num > TickOne) && (tick_num < TickEdge);
        end else begin
            sample_now = tick_num[0] && (tick_num < TickEdge);
            shift_now  = !tick_num[0] && (tick_num < TickEdgeM);
        end
    end

    // FSM next state and datapath updates.
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        mosi_d     = mosi_q;
        sck_d      = sck_q;
        done_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;
`ifdef SPI_LSB_FIRST_EN
        lsb_d      = lsb_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StRun;
                    cpol_d     = bus.cpol;
                    cpha_d     = bus.cpha;
                    div_d      = bus.clk_div;
                    tx_d       = bus.data_in;
                    rx_d       = '0;
                    mosi_d     = first_bit;
                    sck_d      = bus.cpol;
                    tick_cnt_d = '0;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d      = bus.lsb_first;
`endif
                end
            end
            StRun: begin
                if (tick) begin
                    tick_cnt_d = tick_num;
                    if (tick_num <= TickEdge) begin
                        sck_d = ~sck_q;
                    end
                    if (sample_now) begin
                        rx_d = rx_shift;
                    end
                    if (shift_now) begin
                        tx_d   = tx_shift;
                        mosi_d = next_bit;
                    end
                    // Final tick: SCK is already back at idle, publish the byte.
                    if (tick_num == TickLast) begin
                        state_d    = StIdle;
                        done_d     = 1'b1;
                        data_out_d = rx_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q    <= StIdle;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            mosi_q     <= 1'b0;
            sck_q      <= 1'b0;
            done_q     <= 1'b0;
            tick_cnt_q <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            mosi_q     <= mosi_d;
            sck_q      <= sck_d;
            done_q     <= done_d;
            tick_cnt_q <= tick_cnt_d;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= lsb_d;
`endif
        end
    end

    // In IDLE SCK follows the live cpol so the line idles correctly before a start.
    assign bus.sck      = run ? sck_q : bus.cpol;
    assign bus.mosi     = mosi_q;
    assign bus.busy     = run;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;

endmodule
